// File: rtl/hash_target_cmp_seq_if.sv
// Handshake and operand/result bundle between the nonce-search control and
// the sequential hash-versus-target comparator.
interface hash_target_cmp_seq_if #(
    parameter int unsigned NBYTES = 32,
    parameter int unsigned CW     = $clog2(NBYTES + 1)
);
    logic                  start;
    logic                  abort;
    logic [8*NBYTES-1:0]   hash_in;
    logic [8*NBYTES-1:0]   target_in;
    logic                  busy;
    logic                  done;
    logic                  res_valid;
    logic                  lt;
    logic                  eq;
    logic                  gt;
    logic                  hash_ok;
    logic [CW-1:0]         bytes_cmp;

    modport master (
        output start, abort, hash_in, target_in,
        input  busy, done, res_valid, lt, eq, gt, hash_ok, bytes_cmp
    );

    modport slave (
        input  start, abort, hash_in, target_in,
        output busy, done, res_valid, lt, eq, gt, hash_ok, bytes_cmp
    );
endinterface

// File: rtl/hash_target_cmp_seq.sv
// Sequential hash <= target check: latches both operands, then walks them MSB
// byte first through one 8-bit comparator, exiting on the first unequal byte.
module hash_target_cmp_seq #(
    parameter int unsigned NBYTES = 32,
    parameter int unsigned CW     = $clog2(NBYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    hash_target_cmp_seq_if.slave  bus
);
    localparam int unsigned IW = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state_q, state_d;
    logic [8*NBYTES-1:0] hash_q, tgt_q;
    logic [IW-1:0]       idx_q;
    logic [7:0]          hash_byte, tgt_byte;
    logic                byte_lt, byte_eq;
    logic                accept, finish;
    logic                res_valid_q, lt_q, eq_q, gt_q, hash_ok_q;
    logic [CW-1:0]       bytes_cmp_q;

    assign hash_byte = hash_q[{idx_q, 3'b000} +: 8];
    assign tgt_byte  = tgt_q[{idx_q, 3'b000} +: 8];
    assign byte_lt   = hash_byte < tgt_byte;
    assign byte_eq   = hash_byte == tgt_byte;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start && !bus.abort) begin
                    state_d = SCAN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (!byte_eq || idx_q == '0) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hash_q      <= '0;
            tgt_q       <= '0;
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            hash_ok_q   <= 1'b0;
            bytes_cmp_q <= '0;
        end else if (accept) begin
            hash_q      <= bus.hash_in;
            tgt_q       <= bus.target_in;
            idx_q       <= IW'(NBYTES - 1);
            res_valid_q <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            hash_ok_q   <= 1'b0;
            bytes_cmp_q <= '0;
        end else if (finish) begin
            // Equal operands reach idx 0, so NBYTES-idx also covers the eq case.
            res_valid_q <= 1'b1;
            lt_q        <= byte_lt;
            eq_q        <= byte_eq;
            gt_q        <= !byte_lt && !byte_eq;
            hash_ok_q   <= byte_lt || byte_eq;
            bytes_cmp_q <= CW'(NBYTES) - CW'(idx_q);
        end else if (state_q == SCAN && !bus.abort) begin
            idx_q <= idx_q - 1'b1;
        end
    end

    assign bus.busy      = (state_q == SCAN);
    assign bus.done      = (state_q == DONE);
    assign bus.res_valid = res_valid_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.hash_ok   = hash_ok_q;
    assign bus.bytes_cmp = bytes_cmp_q;
endmodule

// File: doc/hash_target_cmp_seq.md
# hash_target_cmp_seq

Sequential hash-versus-difficulty-target checker for the mining datapath. It latches a multi-byte hash and target, then walks them MSB byte first through a single shared 8-bit magnitude comparator, one byte per cycle. It exits early on the first unequal byte and reports lt/eq/gt plus a pass flag (hash <= target) to the nonce-search control.

## Interface
- NBYTES, default 32: operand width in bytes; legal range 2..64.
- CW, default $clog2(NBYTES+1): width of the byte-count output.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a comparison; sampled at rising edge.
- abort  in  1  cancel an in-progress scan; synchronous.
- hash_in  in  8*NBYTES  hash operand, byte NBYTES-1 = bits [8*NBYTES-1 -: 8] = most significant.
- target_in  in  8*NBYTES  target operand, same byte order.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse, result complete.
- res_valid  out  1  result outputs hold a completed comparison.
- lt, eq, gt  out  1 each  hash <, =, > target; exactly one high when res_valid=1, all 0 otherwise.
- hash_ok  out  1  lt | eq.
- bytes_cmp  out  CW  bytes examined in the last completed scan (1..NBYTES).

## Operation
- States: IDLE, SCAN, DONE. Reset state IDLE.
- Reset (async, any state): state=IDLE; busy, done, res_valid, lt, eq, gt, hash_ok=0; bytes_cmp=0; internal operand registers and byte index cleared.
- IDLE or DONE, start=1, abort=0: latch hash_in and target_in into internal registers, idx=NBYTES-1, clear res_valid/lt/eq/gt/hash_ok/bytes_cmp, go to SCAN. Inputs after the latching edge have no effect.
- IDLE or DONE, start=0 or abort=1: go to or stay in IDLE. DONE always lasts exactly one cycle.
- SCAN, per cycle: compare byte idx of the latched hash and latched target as unsigned 8-bit values, using a single comparator only.
  - abort=1: go to IDLE. No done pulse. res_valid, lt, eq, gt and hash_ok remain 0. abort takes priority over the compare result.
  - Unequal byte: set gt or lt, hash_ok=lt, bytes_cmp=NBYTES-idx, res_valid=1, go to DONE.
  - Equal byte with idx=0: eq=1, hash_ok=1, bytes_cmp=NBYTES, res_valid=1, go to DONE.
  - Equal byte with idx>0: idx decrements, stay in SCAN.
- start while in SCAN is ignored; it is neither queued nor restarts the scan.
- Results hold through DONE and IDLE until the next accepted start or reset.
- Comparison is unsigned across the full 8*NBYTES-bit value.

## Timing
- The start accept edge is E0. Bytes examined is k, where k=1 for a first-byte mismatch and k=NBYTES for equal operands.
- busy=1 for cycles following E0 through E0+k-1, i.e. k cycles.
- Result outputs and res_valid update at edge E0+k. done=1 for the single cycle after E0+k.
- Start-to-done latency is k+1 edges: best case 2, worst case NBYTES+1.
- A start in the DONE cycle is accepted, so back-to-back scans are possible. The previous results clear at that edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Abort sampled at edge Ea: busy=0 after Ea.

## Test plan
All scenarios use NBYTES=4.
- hash=32'h0000_00FF, target=32'h0001_0000, pulse start -> byte3 equal, byte2 00<01: lt=1, hash_ok=1, bytes_cmp=2, busy for 2 cycles, done pulse 3 edges after start.
- hash=target=32'hDEAD_BEEF -> eq=1, hash_ok=1, gt=lt=0, bytes_cmp=4, done 5 edges after start.
- hash=32'h8000_0000, target=32'h7FFF_FFFF -> gt=1, hash_ok=0, bytes_cmp=1, done 2 edges after start. Change hash_in to 0 one cycle after start -> result unchanged.
- Equal operands, start, then abort=1 at the second SCAN edge -> IDLE next cycle, busy=0, no done, res_valid=0. A start pulsed while busy before the abort produces no extra scan.
- Assert rst asynchronously mid-SCAN, between clock edges -> all outputs 0 immediately, state IDLE. After release, a fresh start with 32'h1 vs 32'h2 gives lt=1, bytes_cmp=4.
- Start held high continuously with alternating operands -> a new scan is accepted in each DONE cycle. Each result matches its own latched operands, with exactly one done per scan.
